// File: rtl/conv_layer_sched_pkg.sv
// Shared types and helpers for the 1-D convolution layer scheduler.
package conv_sched_pkg;

  typedef enum logic [2:0] {
    LOAD,
    CLEAR,
    ISSUE,
    FLUSH,
    WRITE,
    SEND_RD,
    SEND_VAL
  } sched_state_t;

  // Saturate an address at the last valid location.
  function automatic int unsigned clamp_addr(input int unsigned value, input int unsigned max_addr);
    return (value > max_addr) ? max_addr : value;
  endfunction

endpackage

// File: rtl/conv_layer_sched_if.sv
// Stream, memory and MAC control signals between the scheduler and its environment.
interface conv_layer_sched_if #(
  parameter int P       = 1,
  parameter int ADDRX   = 3,
  parameter int ADDRF   = 2,
  parameter int LOGSIZE = 3
);

  logic                 s_valid_x;
  logic                 s_ready_x;
  logic                 x_wr_en;
  logic [ADDRX-1:0]     x_waddr;
  logic [P*ADDRX-1:0]   x_raddr;
  logic [ADDRF-1:0]     f_addr;
  logic                 en_acc;
  logic                 clr_acc;
  logic                 y_wr_en;
  logic [LOGSIZE-1:0]   y_waddr;
  logic [P-1:0]         y_lane_mask;
  logic [LOGSIZE-1:0]   y_raddr;
  logic                 m_valid_y;
  logic                 m_ready_y;
  logic                 busy;

  modport master (
    input  s_valid_x, m_ready_y,
    output s_ready_x, x_wr_en, x_waddr, x_raddr, f_addr, en_acc, clr_acc,
           y_wr_en, y_waddr, y_lane_mask, y_raddr, m_valid_y, busy
  );

  modport slave (
    output s_valid_x, m_ready_y,
    input  s_ready_x, x_wr_en, x_waddr, x_raddr, f_addr, en_acc, clr_acc,
           y_wr_en, y_waddr, y_lane_mask, y_raddr, m_valid_y, busy
  );

endinterface

// File: rtl/conv_layer_sched_lane_addr_gen.sv
// Per-lane X read address generator: lane i reads x[g+i+k], saturated at LENX-1.
module conv_lane_addr_gen
  import conv_sched_pkg::*;
#(
  parameter int LENX    = 8,
  parameter int P       = 1,
  parameter int ADDRX   = 3,
  parameter int ADDRF   = 2,
  parameter int LOGSIZE = 3
) (
  input  logic [LOGSIZE:0]     g,
  input  logic [ADDRF:0]       k,
  output logic [P*ADDRX-1:0]   x_raddr
);

  // Sum in 32 bits so lanes past the end of X saturate instead of wrapping.
  always_comb begin
    x_raddr = '0;
    for (int i = 0; i < P; i++) begin
      x_raddr[i*ADDRX +: ADDRX] =
        ADDRX'(clamp_addr(32'(g) + 32'(k) + 32'(i), LENX - 1));
    end
  end

endmodule

// File: rtl/conv_layer_sched.sv
// Scheduler for one 1-D convolution layer: load X, issue MAC groups, commit, drain Y.
module conv_layer_sched
  import conv_sched_pkg::*;
#(
  parameter int LENX    = 8,
  parameter int LENF    = 4,
  parameter int P       = 1,
  parameter int ADDRX   = 3,
  parameter int ADDRF   = 2,
  parameter int SIZE    = LENX - LENF + 1,
  parameter int LOGSIZE = 3
) (
  input  logic                clk,
  input  logic                reset,
  conv_layer_sched_if.master  bus
);

  sched_state_t         state, state_n;
  logic [ADDRX:0]       load_cnt, load_cnt_n;
  logic [LOGSIZE:0]     g, g_n;
  logic [ADDRF:0]       k, k_n;
  logic [LOGSIZE-1:0]   rd, rd_n;
  logic                 en_acc_q;
  logic [LOGSIZE:0]     g_step;
  logic                 accept;

  assign g_step        = g + (LOGSIZE+1)'(P);
  assign bus.s_ready_x = (state == LOAD) && reset;
  assign accept        = bus.s_ready_x && bus.s_valid_x;
  assign bus.x_wr_en   = accept;
  assign bus.x_waddr   = load_cnt[ADDRX-1:0];
  assign bus.f_addr    = k[ADDRF-1:0];
  assign bus.en_acc    = en_acc_q;
  assign bus.y_waddr   = g[LOGSIZE-1:0];
  assign bus.y_raddr   = rd;
  assign bus.busy      = (state != LOAD);

  conv_lane_addr_gen #(
    .LENX    (LENX),
    .P       (P),
    .ADDRX   (ADDRX),
    .ADDRF   (ADDRF),
    .LOGSIZE (LOGSIZE)
  ) u_addr_gen (
    .g       (g),
    .k       (k),
    .x_raddr (bus.x_raddr)
  );

  // State, counters, and en_acc delayed one cycle to match the memory read latency.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= LOAD;
      load_cnt <= '0;
      g        <= '0;
      k        <= '0;
      rd       <= '0;
      en_acc_q <= 1'b0;
    end else begin
      state    <= state_n;
      load_cnt <= load_cnt_n;
      g        <= g_n;
      k        <= k_n;
      rd       <= rd_n;
      en_acc_q <= (state == ISSUE);
    end
  end

  // Next-state, counter updates and phase strobes.
  always_comb begin
    state_n       = state;
    load_cnt_n    = load_cnt;
    g_n           = g;
    k_n           = k;
    rd_n          = rd;
    bus.clr_acc   = 1'b0;
    bus.y_wr_en   = 1'b0;
    bus.m_valid_y = 1'b0;
    case (state)
      LOAD: begin
        bus.clr_acc = 1'b1;
        if (accept) begin
          if (load_cnt == (ADDRX+1)'(LENX - 1)) begin
            load_cnt_n = '0;
            g_n        = '0;
            state_n    = CLEAR;
          end else begin
            load_cnt_n = load_cnt + 1'b1;
          end
        end
      end
      CLEAR: begin
        bus.clr_acc = 1'b1;
        k_n         = '0;
        state_n     = ISSUE;
      end
      ISSUE: begin
        if (k == (ADDRF+1)'(LENF - 1)) begin
          state_n = FLUSH;
        end else begin
          k_n = k + 1'b1;
        end
      end
      FLUSH: begin
        state_n = WRITE;
      end
      WRITE: begin
        bus.y_wr_en = 1'b1;
        g_n         = g_step;
        if (g_step >= (LOGSIZE+1)'(SIZE)) begin
          rd_n    = '0;
          state_n = SEND_RD;
        end else begin
          state_n = CLEAR;
        end
      end
      SEND_RD: begin
        state_n = SEND_VAL;
      end
      SEND_VAL: begin
        bus.m_valid_y = 1'b1;
        if (bus.m_ready_y) begin
          if (rd == LOGSIZE'(SIZE - 1)) begin
            load_cnt_n = '0;
            g_n        = '0;
            k_n        = '0;
            rd_n       = '0;
            state_n    = LOAD;
          end else begin
            rd_n    = rd + 1'b1;
            state_n = SEND_RD;
          end
        end
      end
      default: begin
        state_n = LOAD;
      end
    endcase
  end

  // Only lanes that map onto a real output are committed during WRITE.
  always_comb begin
    bus.y_lane_mask = '0;
    if (state == WRITE) begin
      for (int i = 0; i < P; i++) begin
        bus.y_lane_mask[i] = (32'(g) + 32'(i) < 32'(SIZE));
      end
    end
  end

endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched with a P=1 and a P=2 instance (LENX=8, LENF=4).
module tb_conv_layer_sched;

  typedef struct {
    int          w;
    int          n;
    logic [18:0] exp;
    logic [18:0] care;
  } vec_t;

  // Control field {s_ready_x, clr_acc, en_acc, y_wr_en, m_valid_y, busy}
  localparam logic [5:0] C_LOAD  = 6'b110000;
  localparam logic [5:0] C_CLEAR = 6'b010001;
  localparam logic [5:0] C_IDLE  = 6'b000001;
  localparam logic [5:0] C_ACC   = 6'b001001;
  localparam logic [5:0] C_WRITE = 6'b000101;
  localparam logic [5:0] C_SEND  = 6'b000011;

  logic clk  = 1'b0;
  logic rst1 = 1'b0;
  logic rst2 = 1'b0;

  int pass_count  = 0;
  int check_count = 0;

  logic [18:0] trace [1:2][0:39];
  vec_t        tbl [$];

  always #5 clk = ~clk;

  conv_layer_sched_if #(.P(1), .ADDRX(3), .ADDRF(2), .LOGSIZE(3)) bus1 ();
  conv_layer_sched_if #(.P(2), .ADDRX(3), .ADDRF(2), .LOGSIZE(3)) bus2 ();

  conv_layer_sched #(
    .LENX(8), .LENF(4), .P(1), .ADDRX(3), .ADDRF(2), .SIZE(5), .LOGSIZE(3)
  ) dut1 (
    .clk   (clk),
    .reset (rst1),
    .bus   (bus1)
  );

  conv_layer_sched #(
    .LENX(8), .LENF(4), .P(2), .ADDRX(3), .ADDRF(2), .SIZE(5), .LOGSIZE(3)
  ) dut2 (
    .clk   (clk),
    .reset (rst2),
    .bus   (bus2)
  );

  function automatic vec_t mk(input int w, input int n, input logic [5:0] ctl,
                              input logic chk_i, input logic [1:0] f,
                              input logic [2:0] x0, input logic [2:0] x1,
                              input logic chk_w, input logic [2:0] ywa,
                              input logic [1:0] m);
    vec_t v;
    v.w    = w;
    v.n    = n;
    v.exp  = {ctl, f, x0, x1, ywa, m};
    v.care = {6'h3f, {8{chk_i}}, {5{chk_w}}};
    return v;
  endfunction

  function automatic logic [18:0] observe(input int w);
    if (w == 1) begin
      return {bus1.s_ready_x, bus1.clr_acc, bus1.en_acc, bus1.y_wr_en, bus1.m_valid_y,
              bus1.busy, bus1.f_addr, bus1.x_raddr, 3'b000, bus1.y_waddr,
              1'b0, bus1.y_lane_mask};
    end
    return {bus2.s_ready_x, bus2.clr_acc, bus2.en_acc, bus2.y_wr_en, bus2.m_valid_y,
            bus2.busy, bus2.f_addr, bus2.x_raddr[2:0], bus2.x_raddr[5:3], bus2.y_waddr,
            bus2.y_lane_mask};
  endfunction

  function automatic logic [3:0] load_obs(input int w);
    if (w == 1) return {bus1.x_wr_en, bus1.x_waddr};
    return {bus2.x_wr_en, bus2.x_waddr};
  endfunction

  function automatic logic [2:0] rd_addr(input int w);
    if (w == 1) return bus1.y_raddr;
    return bus2.y_raddr;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    check_count++;
    if (act === req) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Drive inputs just after the falling edge; outputs are sampled 1 ns later.
  task automatic applyStimulus(input int w, input logic sv, input logic mr);
    @(negedge clk);
    if (w == 1) begin
      bus1.s_valid_x = sv;
      bus1.m_ready_y = mr;
    end else begin
      bus2.s_valid_x = sv;
      bus2.m_ready_y = mr;
    end
    #1;
  endtask

  // Stream 8 samples back to back, then record 39 cycles after the last accept.
  task automatic runFrame(input int w);
    int          extra;
    logic [3:0]  lo;
    extra = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(w, 1'b1, 1'b0);
      checkOutput($sformatf("p%0d_load_write_%0d", w, c), 32'(load_obs(w)), 32'({1'b1, 3'(c)}));
      if (c == 7) trace[w][0] = observe(w);
    end
    for (int n = 1; n < 40; n++) begin
      applyStimulus(w, 1'b1, 1'b0);
      trace[w][n] = observe(w);
      lo = load_obs(w);
      if (lo[3]) extra++;
    end
    checkOutput($sformatf("p%0d_no_write_outside_load", w), extra, 0);
  endtask

  task automatic compareTable(input int w);
    foreach (tbl[i]) begin
      if (tbl[i].w == w) begin
        checkOutput($sformatf("p%0d_cycle_%0d", w, tbl[i].n),
                    32'(trace[w][tbl[i].n] & tbl[i].care),
                    32'(tbl[i].exp & tbl[i].care));
      end
    end
  endtask

  // Accept outputs every cycle until the scheduler is back in LOAD.
  task automatic drain(input int w);
    int          hs;
    logic        done;
    logic [18:0] o;
    hs   = 0;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      applyStimulus(w, 1'b0, 1'b1);
      o = observe(w);
      if (o[18]) begin
        done = 1'b1;
      end else if (o[14]) begin
        checkOutput($sformatf("p%0d_y_raddr_hs%0d", w, hs), 32'(rd_addr(w)), hs);
        hs++;
      end
    end
    checkOutput($sformatf("p%0d_handshakes", w), hs, 5);
    checkOutput($sformatf("p%0d_ready_after_drain", w), 32'(done), 1);
  endtask

  initial begin
    logic        stable;
    logic [3:0]  lo;
    logic [18:0] o;
    int          pulses;

    bus1.s_valid_x = 1'b0;
    bus1.m_ready_y = 1'b0;
    bus2.s_valid_x = 1'b0;
    bus2.m_ready_y = 1'b0;

    tbl.push_back(mk(1,  0, C_LOAD,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,  1, C_CLEAR, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,  2, C_IDLE,  1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,  3, C_ACC,   1, 1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1,  4, C_ACC,   1, 2, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1,  5, C_ACC,   1, 3, 3, 0, 0, 0, 0));
    tbl.push_back(mk(1,  6, C_ACC,   0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,  7, C_WRITE, 0, 0, 0, 0, 1, 0, 2'b01));
    tbl.push_back(mk(1,  8, C_CLEAR, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 14, C_WRITE, 0, 0, 0, 0, 1, 1, 2'b01));
    tbl.push_back(mk(1, 30, C_IDLE,  1, 0, 4, 0, 0, 0, 0));
    tbl.push_back(mk(1, 31, C_ACC,   1, 1, 5, 0, 0, 0, 0));
    tbl.push_back(mk(1, 32, C_ACC,   1, 2, 6, 0, 0, 0, 0));
    tbl.push_back(mk(1, 33, C_ACC,   1, 3, 7, 0, 0, 0, 0));
    tbl.push_back(mk(1, 35, C_WRITE, 0, 0, 0, 0, 1, 4, 2'b01));
    tbl.push_back(mk(1, 36, C_IDLE,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 37, C_SEND,  0, 0, 0, 0, 0, 0, 0));

    tbl.push_back(mk(2,  0, C_LOAD,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2,  2, C_IDLE,  1, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(2,  5, C_ACC,   1, 3, 3, 4, 0, 0, 0));
    tbl.push_back(mk(2,  7, C_WRITE, 0, 0, 0, 0, 1, 0, 2'b11));
    tbl.push_back(mk(2,  9, C_IDLE,  1, 0, 2, 3, 0, 0, 0));
    tbl.push_back(mk(2, 14, C_WRITE, 0, 0, 0, 0, 1, 2, 2'b11));
    tbl.push_back(mk(2, 16, C_IDLE,  1, 0, 4, 5, 0, 0, 0));
    tbl.push_back(mk(2, 17, C_ACC,   1, 1, 5, 6, 0, 0, 0));
    tbl.push_back(mk(2, 18, C_ACC,   1, 2, 6, 7, 0, 0, 0));
    tbl.push_back(mk(2, 19, C_ACC,   1, 3, 7, 7, 0, 0, 0));
    tbl.push_back(mk(2, 21, C_WRITE, 0, 0, 0, 0, 1, 4, 2'b01));
    tbl.push_back(mk(2, 22, C_IDLE,  0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(2, 23, C_SEND,  0, 0, 0, 0, 0, 0, 0));

    // Reset cycle with valid high: nothing may be accepted.
    applyStimulus(1, 1'b1, 1'b0);
    checkOutput("reset_cycle_ready_write", 32'({bus1.s_ready_x, bus1.x_wr_en}), 0);

    @(negedge clk);
    rst1 = 1'b1;
    bus1.s_valid_x = 1'b0;
    #1;
    o = observe(1);
    checkOutput("reset_state_ctl", 32'(o[18:13]), 32'(C_LOAD));
    checkOutput("reset_state_waddr", 32'(load_obs(1)), 0);

    // P=1 frame, then 10 cycles of output backpressure.
    runFrame(1);
    compareTable(1);
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 1'b0, 1'b0);
      if (!(bus1.m_valid_y && bus1.y_raddr == 3'd0)) stable = 1'b0;
    end
    checkOutput("p1_backpressure_hold", 32'(stable), 1);
    drain(1);

    // Reset in the middle of ISSUE, then a clean frame.
    for (int c = 0; c < 10; c++) applyStimulus(1, 1'b1, 1'b0);
    @(negedge clk);
    rst1 = 1'b0;
    #1;
    checkOutput("mid_issue_en_busy", 32'({bus1.en_acc, bus1.busy}), 32'(2'b11));
    @(negedge clk);
    rst1 = 1'b1;
    bus1.s_valid_x = 1'b0;
    #1;
    o = observe(1);
    checkOutput("after_reset_ctl", 32'(o[18:13]), 32'(C_LOAD));
    runFrame(1);
    compareTable(1);
    drain(1);

    // Bubbled input stream.
    pulses = 0;
    for (int i = 0; i < 30; i++) begin
      applyStimulus(1, (i % 2) == 0, 1'b0);
      lo = load_obs(1);
      if (lo[3]) begin
        checkOutput($sformatf("bubble_addr_%0d", pulses), 32'(lo[2:0]), pulses);
        pulses++;
      end
    end
    checkOutput("bubble_write_count", pulses, 8);

    // P=2 instance: clamping, lane mask, three commits.
    @(negedge clk);
    rst2 = 1'b1;
    runFrame(2);
    compareTable(2);
    pulses = 0;
    for (int n = 0; n < 40; n++) begin
      if (trace[2][n][15]) pulses++;
    end
    checkOutput("p2_write_pulses", pulses, 3);
    drain(2);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
